sin_rom_arbiter: RTL and testbench

Shares one synchronous sine ROM (1-cycle registered read, 2048 × 16-bit signed samples) between `N_REQ` independent DDFS channels. Each cycle the block picks at most one requester round-robin, drives its address to the ROM, and returns the ROM data to that requester. Each response is tagged by a one-hot valid a fixed number of cycles later. It sits between the per-channel phase accumulators and the single `sin_rom` instance.

---
 rtl/sin_rom_pkg.sv | 10 +
 rtl/rr_picker.sv | 30 +++
 rtl/sin_rom_arbiter.sv | 90 +++++++++
 tb/tb_sin_rom_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sin_rom_pkg.sv
// Constants and sample type shared by the sine ROM and everything that talks to it.
package sin_rom_pkg;

  localparam int unsigned SIN_ADDR_WIDTH = 11;
  localparam int unsigned SIN_DATA_WIDTH = 16;
  localparam int unsigned ROM_RD_LAT     = 1;

  typedef logic signed [SIN_DATA_WIDTH-1:0] sin_sample_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request at or after i_ptr, ascending, wrapping at N.
module rr_picker #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [IW-1:0] cand;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IW'((32'(i_ptr) + i) % N);
      if (!o_any && i_req[cand]) begin
        o_any       = 1'b1;
        o_gnt[cand] = 1'b1;
        o_idx       = cand;
      end
    end
  end

endmodule

// File: rtl/sin_rom_arbiter.sv
// Round-robin sharing of one registered-read sine ROM between N_REQ DDFS channels,
// returning each sample with a one-hot valid aligned to the ROM read latency.
module sin_rom_arbiter
  import sin_rom_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned ADDR_WIDTH = SIN_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = SIN_DATA_WIDTH,
  parameter bit          OUT_REG    = 1'b0
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [N_REQ-1:0]              i_req,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   i_addr,
  output logic [N_REQ-1:0]              o_gnt,
  output logic [ADDR_WIDTH-1:0]         o_rom_addr,
  input  logic [DATA_WIDTH-1:0]         i_rom_data,
  output logic [N_REQ-1:0]              o_rsp_valid,
  output logic [DATA_WIDTH-1:0]         o_rsp_data
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]    pick_idx;
  logic [N_REQ-1:0] pick_gnt;
  logic             pick_any;
  logic [N_REQ-1:0] tag_q;

  rr_picker #(
    .N  (N_REQ),
    .IW (PW)
  ) u_picker (
    .i_req (i_req),
    .i_ptr (rr_ptr_q),
    .o_gnt (pick_gnt),
    .o_idx (pick_idx),
    .o_any (pick_any)
  );

  // Grant is suppressed during reset so nothing new enters the pipeline.
  always_comb begin
    o_gnt      = i_reset ? '0 : pick_gnt;
    o_rom_addr = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (o_gnt[k]) o_rom_addr = i_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (pick_any) begin
      rr_ptr_d = (32'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + PW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rr_ptr_q <= '0;
      tag_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      tag_q    <= o_gnt;
    end
  end

  generate
    if (OUT_REG) begin : g_out_reg
      logic [N_REQ-1:0]      valid_q;
      logic [DATA_WIDTH-1:0] data_q;

      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          valid_q <= '0;
          data_q  <= '0;
        end else begin
          valid_q <= tag_q;
          data_q  <= i_rom_data;
        end
      end

      assign o_rsp_valid = valid_q;
      assign o_rsp_data  = data_q;
    end else begin : g_no_out_reg
      assign o_rsp_valid = tag_q;
      assign o_rsp_data  = i_rom_data;
    end
  endgenerate

endmodule

// File: tb/tb_sin_rom_arbiter.sv
// Directed and random checks of sin_rom_arbiter with OUT_REG=0 and OUT_REG=1 side by side.
module tb_sin_rom_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 11;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [N*AW-1:0] addr;
  logic [N-1:0]  gnt0, gnt1, v0, v1;
  logic [AW-1:0] ra0, ra1;
  logic [DW-1:0] rd0, rd1, d0, d1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sin_rom_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(1'b0)) dut0 (
    .i_clk(clk), .i_reset(reset), .i_req(req), .i_addr(addr), .o_gnt(gnt0),
    .o_rom_addr(ra0), .i_rom_data(rd0), .o_rsp_valid(v0), .o_rsp_data(d0));

  sin_rom_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(1'b1)) dut1 (
    .i_clk(clk), .i_reset(reset), .i_req(req), .i_addr(addr), .o_gnt(gnt1),
    .o_rom_addr(ra1), .i_rom_data(rd1), .o_rsp_valid(v1), .o_rsp_data(d1));

  // ROM stand-in; 0x200 holds the quarter-wave peak.
  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    if (a == 11'h200) return 16'h7FFF;
    return 16'(({5'd0, a} * 16'd37) ^ 16'h5A5A);
  endfunction

  always @(posedge clk) begin
    rd0 <= rom_f(ra0);
    rd1 <= rom_f(ra1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 4'hF; addr = {11'd3, 11'd2, 11'd1, 11'd0};
    tick(); tick(); #1;
    checks++; if (gnt0 !== 4'b0000) begin errors++; $display("FAIL reset_gnt0: got %b exp 0000", gnt0); end
    checks++; if (gnt1 !== 4'b0000) begin errors++; $display("FAIL reset_gnt1: got %b exp 0000", gnt1); end
    checks++; if (ra0 !== 11'h000) begin errors++; $display("FAIL reset_rom_addr: got %h exp 000", ra0); end
    checks++; if (v0 !== 4'b0000) begin errors++; $display("FAIL reset_valid0: got %b exp 0000", v0); end
    checks++; if (v1 !== 4'b0000) begin errors++; $display("FAIL reset_valid1: got %b exp 0000", v1); end
    checks++; if (d1 !== 16'h0000) begin errors++; $display("FAIL reset_data1: got %h exp 0000", d1); end
    reset = 1'b0; req = 4'b0000;
    tick();
  endtask

  task automatic test_single();
    addr = {11'h000, 11'h200, 11'h000, 11'h000};
    req = 4'b0100; #1;
    checks++; if (gnt0 !== 4'b0100) begin errors++; $display("FAIL single_gnt0: got %b exp 0100", gnt0); end
    checks++; if (gnt1 !== 4'b0100) begin errors++; $display("FAIL single_gnt1: got %b exp 0100", gnt1); end
    checks++; if (ra0 !== 11'h200) begin errors++; $display("FAIL single_rom_addr: got %h exp 200", ra0); end
    tick(); req = 4'b0000; #1;
    checks++; if (v0 !== 4'b0100) begin errors++; $display("FAIL single_valid0: got %b exp 0100", v0); end
    checks++; if (d0 !== 16'h7FFF) begin errors++; $display("FAIL single_data0: got %h exp 7fff", d0); end
    checks++; if (v1 !== 4'b0000) begin errors++; $display("FAIL single_valid1_early: got %b exp 0000", v1); end
    tick(); #1;
    checks++; if (v0 !== 4'b0000) begin errors++; $display("FAIL single_valid0_once: got %b exp 0000", v0); end
    checks++; if (v1 !== 4'b0100) begin errors++; $display("FAIL single_valid1: got %b exp 0100", v1); end
    checks++; if (d1 !== 16'h7FFF) begin errors++; $display("FAIL single_data1: got %h exp 7fff", d1); end
    tick();
  endtask

  task automatic test_rotate();
    logic [3:0] eg;
    reset = 1'b1; req = 4'b0000;
    tick();
    reset = 1'b0; addr = {11'd3, 11'd2, 11'd1, 11'd0}; req = 4'hF;
    for (int i = 0; i < 8; i++) begin
      #1;
      eg = 4'(1 << (i % 4));
      checks++; if (gnt0 !== eg) begin errors++; $display("FAIL rotate_gnt[%0d]: got %b exp %b", i, gnt0, eg); end
      checks++; if (ra0 !== 11'(i % 4)) begin errors++; $display("FAIL rotate_rom_addr[%0d]: got %h exp %h", i, ra0, 11'(i % 4)); end
      if (i >= 1) begin
        eg = 4'(1 << ((i - 1) % 4));
        checks++; if (v0 !== eg) begin errors++; $display("FAIL rotate_valid0[%0d]: got %b exp %b", i, v0, eg); end
        checks++; if (d0 !== rom_f(11'((i - 1) % 4))) begin errors++; $display("FAIL rotate_data0[%0d]: got %h exp %h", i, d0, rom_f(11'((i - 1) % 4))); end
      end
      if (i >= 2) begin
        eg = 4'(1 << ((i - 2) % 4));
        checks++; if (v1 !== eg) begin errors++; $display("FAIL rotate_valid1[%0d]: got %b exp %b", i, v1, eg); end
        checks++; if (d1 !== rom_f(11'((i - 2) % 4))) begin errors++; $display("FAIL rotate_data1[%0d]: got %h exp %h", i, d1, rom_f(11'((i - 2) % 4))); end
      end
      tick();
    end
    req = 4'b0000; #1;
    checks++; if (v0 !== 4'b1000) begin errors++; $display("FAIL rotate_tail_valid0: got %b exp 1000", v0); end
    checks++; if (v1 !== 4'b0100) begin errors++; $display("FAIL rotate_tail_valid1: got %b exp 0100", v1); end
    tick();
  endtask

  task automatic test_fairness();
    logic [3:0] rq [5];
    logic [3:0] eg [5];
    rq = '{4'b0001, 4'b0001, 4'b1001, 4'b1001, 4'b1001};
    eg = '{4'b0001, 4'b0001, 4'b1000, 4'b0001, 4'b1000};
    addr = {11'h333, 11'h000, 11'h000, 11'h010};
    for (int i = 0; i < 5; i++) begin
      req = rq[i]; #1;
      checks++; if (gnt0 !== eg[i]) begin errors++; $display("FAIL fair_gnt[%0d]: got %b exp %b", i, gnt0, eg[i]); end
      checks++; if (ra0 !== ((eg[i] == 4'b1000) ? 11'h333 : 11'h010)) begin errors++; $display("FAIL fair_rom_addr[%0d]: got %h", i, ra0); end
      tick();
    end
    req = 4'b0000; #1;
    checks++; if (v0 !== 4'b1000) begin errors++; $display("FAIL fair_valid0: got %b exp 1000", v0); end
    checks++; if (d0 !== rom_f(11'h333)) begin errors++; $display("FAIL fair_data0: got %h exp %h", d0, rom_f(11'h333)); end
    tick();
  endtask

  task automatic test_withdraw();
    for (int i = 0; i < 8; i++) begin
      req = (i == 0) ? 4'b0011 : ((i < 5) ? 4'b0001 : 4'b0000); #1;
      if (i < 5) begin
        checks++; if (gnt0 !== 4'b0001) begin errors++; $display("FAIL withdraw_gnt[%0d]: got %b exp 0001", i, gnt0); end
      end
      checks++; if (v0[1] !== 1'b0 || v1[1] !== 1'b0) begin errors++; $display("FAIL withdraw_valid1[%0d]: got %b/%b exp bit1=0", i, v0, v1); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    addr = {11'd3, 11'd2, 11'd1, 11'd0};
    req = 4'hF; #1;
    checks++; if (gnt0 !== 4'b0010) begin errors++; $display("FAIL mid_gnt_a: got %b exp 0010", gnt0); end
    tick(); #1;
    checks++; if (gnt0 !== 4'b0100) begin errors++; $display("FAIL mid_gnt_b: got %b exp 0100", gnt0); end
    tick();
    reset = 1'b1; #1;
    checks++; if (gnt0 !== 4'b0000 || gnt1 !== 4'b0000) begin errors++; $display("FAIL mid_gnt_in_reset: got %b/%b exp 0000", gnt0, gnt1); end
    checks++; if (ra0 !== 11'h000) begin errors++; $display("FAIL mid_rom_addr_in_reset: got %h exp 000", ra0); end
    checks++; if (v0 !== 4'b0100) begin errors++; $display("FAIL mid_valid0_pre_edge: got %b exp 0100", v0); end
    checks++; if (d0 !== rom_f(11'd2)) begin errors++; $display("FAIL mid_data0_pre_edge: got %h exp %h", d0, rom_f(11'd2)); end
    checks++; if (v1 !== 4'b0010) begin errors++; $display("FAIL mid_valid1_pre_edge: got %b exp 0010", v1); end
    tick();
    reset = 1'b0; req = 4'b1100; #1;
    checks++; if (v0 !== 4'b0000 || v1 !== 4'b0000) begin errors++; $display("FAIL mid_valid_dropped: got %b/%b exp 0000", v0, v1); end
    checks++; if (gnt0 !== 4'b0100) begin errors++; $display("FAIL mid_first_gnt: got %b exp 0100", gnt0); end
    checks++; if (ra0 !== 11'd2) begin errors++; $display("FAIL mid_first_rom_addr: got %h exp 002", ra0); end
    tick();
    req = 4'b0000; #1;
    checks++; if (v1 !== 4'b0000) begin errors++; $display("FAIL mid_valid1_dropped: got %b exp 0000", v1); end
    checks++; if (v0 !== 4'b0100) begin errors++; $display("FAIL mid_valid0_new: got %b exp 0100", v0); end
    tick(); #1;
    checks++; if (v1 !== 4'b0100) begin errors++; $display("FAIL mid_valid1_new: got %b exp 0100", v1); end
    tick();
  endtask

  task automatic test_sweep();
    int ptr_m;
    int c;
    int win;
    logic [3:0] eg, pg1, pg2;
    logic [AW-1:0] ea, pa1, pa2;
    reset = 1'b1; req = 4'b0000;
    tick();
    reset = 1'b0;
    ptr_m = 0; pg1 = '0; pg2 = '0; pa1 = '0; pa2 = '0;
    for (int n = 0; n < 10000; n++) begin
      req  = 4'($urandom_range(0, 15));
      addr = 44'({$urandom(), $urandom()});
      #1;
      eg = '0; ea = '0; win = -1;
      for (int j = 0; j < 4; j++) begin
        c = (ptr_m + j) % 4;
        if (win < 0 && req[c]) begin
          win = c; eg[c] = 1'b1; ea = addr[c*AW +: AW];
        end
      end
      checks++; if (gnt0 !== eg || gnt1 !== eg) begin errors++; $display("FAIL sweep_gnt[%0d]: got %b/%b exp %b", n, gnt0, gnt1, eg); end
      checks++; if (ra0 !== ea || ra1 !== ea) begin errors++; $display("FAIL sweep_rom_addr[%0d]: got %h/%h exp %h", n, ra0, ra1, ea); end
      checks++; if (v0 !== pg1) begin errors++; $display("FAIL sweep_valid0[%0d]: got %b exp %b", n, v0, pg1); end
      checks++; if (v1 !== pg2) begin errors++; $display("FAIL sweep_valid1[%0d]: got %b exp %b", n, v1, pg2); end
      if (pg1 != 4'b0000) begin
        checks++; if (d0 !== rom_f(pa1)) begin errors++; $display("FAIL sweep_data0[%0d]: got %h exp %h", n, d0, rom_f(pa1)); end
      end
      if (pg2 != 4'b0000) begin
        checks++; if (d1 !== rom_f(pa2)) begin errors++; $display("FAIL sweep_data1[%0d]: got %h exp %h", n, d1, rom_f(pa2)); end
      end
      pg2 = pg1; pa2 = pa1; pg1 = eg; pa1 = ea;
      if (win >= 0) ptr_m = (win + 1) % 4;
      tick();
    end
    req = 4'b0000;
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    addr  = '0;
    test_reset();
    test_single();
    test_rotate();
    test_fairness();
    test_withdraw();
    test_reset_mid();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
